// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - N-digit BCD up/down counter with prescaler and scanned 7-seg driver
// Count, prescaler and scan paths share iClk; oAn/oSeg lag the scan index by one cycle.
module bcd_scan_counter #(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 50000000,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iEn,
  input  logic                  iUp,
  input  logic                  iClr,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iLoadVal,
  output logic [4*DIGITS-1:0]   oCount,
  output logic                  oTick,
  output logic                  oCarry,
  output logic [6:0]            oSeg,
  output logic [DIGITS-1:0]     oAn
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SDIV_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF       = {7{SEG_ACTIVE_LOW}};

  logic [4*DIGITS-1:0] r_count;
  logic [PW-1:0]       r_presc;
  logic                r_tick;
  logic                r_carry;
  logic [SW-1:0]       r_sdiv;
  logic [IW-1:0]       r_idx;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;

  logic                w_tick;
  logic [4*DIGITS-1:0] w_next;
  logic [4*DIGITS-1:0] w_load_sat;
  logic                w_chain;
  logic                w_wrap;
  logic [3:0]          w_d;
  logic [3:0]          w_digit;
  logic [DIGITS-1:0]   w_an_hot;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: seg_decode = 7'h3F;
      4'd1: seg_decode = 7'h06;
      4'd2: seg_decode = 7'h5B;
      4'd3: seg_decode = 7'h4F;
      4'd4: seg_decode = 7'h66;
      4'd5: seg_decode = 7'h6D;
      4'd6: seg_decode = 7'h7D;
      4'd7: seg_decode = 7'h07;
      4'd8: seg_decode = 7'h7F;
      4'd9: seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign w_tick = iEn && (r_presc == PRESC_LAST);

  // Whole-word step in one cycle: the chain bit marks digits that roll over.
  always_comb begin
    w_next  = r_count;
    w_chain = 1'b1;
    w_d     = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      w_d = r_count[4*k +: 4];
      if (w_chain) begin
        if (iUp) begin
          if (w_d == 4'd9) w_d = 4'd0;
          else begin
            w_d     = w_d + 4'd1;
            w_chain = 1'b0;
          end
        end else begin
          if (w_d == 4'd0) w_d = 4'd9;
          else begin
            w_d     = w_d - 4'd1;
            w_chain = 1'b0;
          end
        end
      end
      w_next[4*k +: 4] = w_d;
    end
    w_wrap = w_chain;
  end

  always_comb begin
    w_load_sat = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_load_sat[4*k +: 4] = (iLoadVal[4*k +: 4] > 4'd9) ? 4'd9 : iLoadVal[4*k +: 4];
    end
  end

  always_comb begin
    w_digit  = 4'd0;
    w_an_hot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_digit     = r_count[4*k +: 4];
        w_an_hot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_count <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (iClr) begin
      r_count <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      if (iEn) r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (iLoad) begin
        r_count <= w_load_sat;
        r_tick  <= 1'b0;
        r_carry <= 1'b0;
      end else if (w_tick) begin
        r_count <= w_next;
        r_tick  <= 1'b1;
        r_carry <= w_wrap;
      end else begin
        r_tick  <= 1'b0;
        r_carry <= 1'b0;
      end
    end
  end

  // Scan timing runs free of iEn/iClr so the display never stalls.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sdiv <= '0;
      r_idx  <= '0;
      r_an   <= AN_OFF;
      r_seg  <= SEG_OFF;
    end else begin
      r_an  <= SEG_ACTIVE_LOW ? ~w_an_hot : w_an_hot;
      r_seg <= SEG_ACTIVE_LOW ? ~seg_decode(w_digit) : seg_decode(w_digit);
      if (r_sdiv == SDIV_LAST) begin
        r_sdiv <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
        r_sdiv <= r_sdiv + SW'(1);
      end
    end
  end

  assign oCount = r_count;
  assign oTick  = r_tick;
  assign oCarry = r_carry;
  assign oSeg   = r_seg;
  assign oAn    = r_an;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - randomized and directed checks against a decimal-integer model
module tb_bcd_scan_counter;

  localparam int DIGITS = 4;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int MODV = 10000;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEn = 1'b0;
  logic        iUp = 1'b1;
  logic        iClr = 1'b0;
  logic        iLoad = 1'b0;
  logic [15:0] iLoadVal = 16'h0;
  logic [15:0] oCount;
  logic        oTick;
  logic        oCarry;
  logic [6:0]  oSeg;
  logic [3:0]  oAn;

  int n_checks = 0;
  int n_errors = 0;

  int m_count, m_presc, m_sdiv, m_idx;
  logic m_tick, m_carry;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_scan_counter #(
    .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iUp(iUp), .iClr(iClr), .iLoad(iLoad),
    .iLoadVal(iLoadVal), .oCount(oCount), .oTick(oTick), .oCarry(oCarry),
    .oSeg(oSeg), .oAn(oAn)
  );

  always #5 iClk = ~iClk;

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int load_dec(input logic [15:0] lv);
    int v = 0;
    int n;
    for (int k = 0; k < DIGITS; k++) begin
      n = int'(lv[4*k +: 4]);
      if (n > 9) n = 9;
      v = v + n * pow10(k);
    end
    return v;
  endfunction

  // Advances the model one clock using the inputs present at the edge.
  task automatic model_update();
    logic tk;
    int dig;
    if (iRst) begin
      m_count = 0; m_presc = 0; m_tick = 0; m_carry = 0;
      m_sdiv = 0; m_idx = 0; m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      tk = iEn && (m_presc == TICK_DIV - 1);
      dig = (m_count / pow10(m_idx)) % 10;
      m_an = ~(4'b0001 << m_idx);
      m_seg = ~seg_tbl[dig];
      if (m_sdiv == SCAN_DIV - 1) begin
        m_sdiv = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else m_sdiv = m_sdiv + 1;
      if (iClr) begin
        m_count = 0; m_presc = 0; m_tick = 0; m_carry = 0;
      end else begin
        if (iEn) m_presc = (m_presc + 1) % TICK_DIV;
        if (iLoad) begin
          m_count = load_dec(iLoadVal); m_tick = 0; m_carry = 0;
        end else if (tk) begin
          m_tick = 1;
          if (iUp) begin
            m_carry = (m_count == MODV - 1);
            m_count = (m_count + 1) % MODV;
          end else begin
            m_carry = (m_count == 0);
            m_count = (m_count + MODV - 1) % MODV;
          end
        end else begin
          m_tick = 0; m_carry = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge iClk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    iRst = 1; cyc(); cyc(); iRst = 0;
    n_checks++; if (oCount !== 16'h0) begin n_errors++; $display("FAIL reset_count got %h want 0000", oCount); end
    n_checks++; if (oTick !== 1'b0 || oCarry !== 1'b0) begin n_errors++; $display("FAIL reset_pulses tick %b carry %b want 0 0", oTick, oCarry); end
    n_checks++; if (oAn !== 4'hF) begin n_errors++; $display("FAIL reset_an got %b want 1111", oAn); end
    n_checks++; if (oSeg !== 7'h7F) begin n_errors++; $display("FAIL reset_seg got %h want 7f", oSeg); end
  endtask

  task automatic test_count_up();
    iEn = 1; iUp = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      n_checks++; if (oCount !== to_bcd(m_count) || oTick !== m_tick || oCarry !== 1'b0) begin
        n_errors++; $display("FAIL count_up cyc %0d got %h/%b/%b want %h/%b/0", i, oCount, oTick, oCarry, to_bcd(m_count), m_tick);
      end
    end
    n_checks++; if (oCount !== 16'h0010) begin n_errors++; $display("FAIL count_up_final got %h want 0010", oCount); end
  endtask

  task automatic test_wrap(input logic up, input logic [15:0] start, input logic [15:0] want);
    int got_tick = 0;
    iEn = 1; iUp = up; iLoad = 1; iLoadVal = start; cyc(); iLoad = 0;
    for (int i = 0; i < 8 && !got_tick; i++) begin cyc(); if (m_tick) got_tick = 1; end
    n_checks++; if (!got_tick) begin n_errors++; $display("FAIL wrap_timeout up=%b no tick within 8 cycles", up); end
    n_checks++; if (oCount !== want || oCarry !== 1'b1) begin n_errors++; $display("FAIL wrap up=%b got %h carry %b want %h carry 1", up, oCount, oCarry, want); end
    cyc();
    n_checks++; if (oCarry !== 1'b0) begin n_errors++; $display("FAIL wrap_carry_len up=%b got %b want 0", up, oCarry); end
  endtask

  task automatic test_load_tick();
    iEn = 1; iUp = 1;
    for (int i = 0; i < 8 && m_presc != TICK_DIV - 1; i++) cyc();
    iLoad = 1; iLoadVal = 16'h1A3F; cyc(); iLoad = 0;
    n_checks++; if (oCount !== 16'h1939 || oTick !== 1'b0 || oCarry !== 1'b0) begin
      n_errors++; $display("FAIL load_tick got %h tick %b carry %b want 1939 0 0", oCount, oTick, oCarry);
    end
  endtask

  task automatic test_clr_load();
    int lat = -1;
    iEn = 1;
    for (int i = 0; i < 8 && m_presc != TICK_DIV - 1; i++) cyc();
    iClr = 1; iLoad = 1; iLoadVal = 16'h5555; cyc(); iClr = 0; iLoad = 0;
    n_checks++; if (oCount !== 16'h0 || oTick !== 1'b0) begin n_errors++; $display("FAIL clr_load got %h tick %b want 0000 0", oCount, oTick); end
    for (int i = 1; i <= 8 && lat < 0; i++) begin cyc(); if (oTick === 1'b1) lat = i; end
    n_checks++; if (lat !== TICK_DIV) begin n_errors++; $display("FAIL clr_next_tick got %0d want %0d", lat, TICK_DIV); end
  endtask

  task automatic test_enable_hold();
    logic [15:0] held;
    int lat = -1;
    int rem;
    iEn = 1; iUp = 1; cyc(); cyc();
    if (m_presc == TICK_DIV - 1) cyc();
    held = to_bcd(m_count); iEn = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++; if (oCount !== held || oTick !== 1'b0) begin n_errors++; $display("FAIL en_hold cyc %0d got %h tick %b want %h 0", i, oCount, oTick, held); end
    end
    rem = TICK_DIV - m_presc; iEn = 1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin cyc(); if (oTick === 1'b1) lat = i; end
    n_checks++; if (lat !== rem) begin n_errors++; $display("FAIL en_resume got %0d want %0d", lat, rem); end
  endtask

  task automatic test_scan();
    iRst = 1; cyc(); iRst = 0;
    iEn = 0; iLoad = 1; iLoadVal = 16'h1234; cyc(); iLoad = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      n_checks++; if (oAn !== m_an || oSeg !== m_seg) begin n_errors++; $display("FAIL scan cyc %0d got an %b seg %h want an %b seg %h", i, oAn, oSeg, m_an, m_seg); end
    end
    iRst = 1; cyc(); iRst = 0;
    n_checks++; if (oAn !== 4'hF || oSeg !== 7'h7F) begin n_errors++; $display("FAIL scan_reset got an %b seg %h want 1111 7f", oAn, oSeg); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      iRst = ($urandom_range(0, 99) == 0);
      iClr = ($urandom_range(0, 39) == 0);
      iLoad = ($urandom_range(0, 19) == 0);
      iEn = ($urandom_range(0, 9) != 0);
      iUp = ($urandom_range(0, 3) != 0) ? iUp : ~iUp;
      iLoadVal = 16'($urandom);
      if (i % 97 == 5) iLoadVal = ($urandom_range(0, 1) != 0) ? 16'h9999 : 16'h0000;
      cyc();
      n_checks++; if (oCount !== to_bcd(m_count) || oTick !== m_tick || oCarry !== m_carry || oAn !== m_an || oSeg !== m_seg) begin
        n_errors++; $display("FAIL random cyc %0d got %h %b %b %b %h want %h %b %b %b %h", i, oCount, oTick, oCarry, oAn, oSeg,
                             to_bcd(m_count), m_tick, m_carry, m_an, m_seg);
      end
    end
    iRst = 0; iClr = 0; iLoad = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap(1'b1, 16'h9999, 16'h0000);
    test_wrap(1'b0, 16'h0000, 16'h9999);
    test_load_tick();
    test_clr_load();
    test_enable_hold();
    test_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
